// File: rtl/psg_reg_decoder_pkg.sv
// Shared types and constants for the PSG register front end.
package psg_pkg;

   typedef enum logic {TONE = 1'b0, ATTN = 1'b1} psg_reg_t;

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} sched_state_t;

   localparam int NUM_TONE = 3;
   localparam int NOISE_CH = 3;
   localparam logic [3:0] ATTN_SILENT = 4'hF;

   // A zero period would make the downstream divider divide by zero.
   function automatic logic [9:0] present_period(input logic [9:0] p);
      return (p == 10'd0) ? 10'd1 : p;
   endfunction

endpackage

// File: rtl/psg_reg_decoder_load_scheduler.sv
// Rate-limits tone load pulses so each divider finishes before the next load.
//   state  | meaning
//   S_IDLE | no load in flight; a request loads at once
//   S_BUSY | counting down; requests are folded into pending
module load_scheduler
   import psg_pkg::*;
#(
   parameter int DIV_CYCLES = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic load
);

   localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV_CYCLES - 1);

   sched_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             load_q, load_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      load_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               load_d  = 1'b1;
               state_d = S_BUSY;
               cnt_d   = RELOAD;
            end
         end
         S_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               if (req) pending_d = 1'b1;
            end else if (pending_q || req) begin
               load_d    = 1'b1;
               pending_d = 1'b0;
               cnt_d     = RELOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         load_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         load_q    <= load_d;
      end
   end

   assign load = load_q;

endmodule

// File: rtl/psg_reg_decoder.sv
// SN76489-style latch/data byte decoder with per-channel tone load scheduling
// and the shared sample tick.
module psg_reg_decoder
   import psg_pkg::*;
#(
   parameter int DIV_CYCLES = 20,
   parameter int SAMPLE_DIV = 2268
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      psg_en,
   input  logic                      wr_en,
   input  logic [7:0]                wr_data,
   output logic [NUM_TONE-1:0][9:0]  tone_freq,
   output logic [NUM_TONE-1:0]       tone_load,
   output logic [3:0][3:0]           attn,
   output logic [2:0]                noise_ctrl,
   output logic                      noise_rst,
   output logic                      acquire
);

   localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

   logic [NUM_TONE-1:0][9:0] freq_q, freq_d;
   logic [NUM_TONE-1:0][9:0] tone_freq_q, tone_freq_d;
   logic [3:0][3:0]          attn_q, attn_d;
   logic [2:0]               noise_q, noise_d;
   logic                     noise_rst_q, noise_rst_d;
   logic [1:0]               lat_ch_q, lat_ch_d;
   psg_reg_t                 lat_type_q, lat_type_d;
   logic [TICK_W-1:0]        tick_q, tick_d;
   logic                     acquire_q, acquire_d;
   logic [NUM_TONE-1:0]      tone_req;
   logic [1:0]               ch;
   psg_reg_t                 typ;

   // Latch bytes carry their own target; data bytes reuse the latched one.
   always_comb begin
      freq_d      = freq_q;
      attn_d      = attn_q;
      noise_d     = noise_q;
      noise_rst_d = 1'b0;
      lat_ch_d    = lat_ch_q;
      lat_type_d  = lat_type_q;
      tone_req    = '0;
      ch          = wr_data[7] ? wr_data[6:5] : lat_ch_q;
      typ         = wr_data[7] ? psg_reg_t'(wr_data[4]) : lat_type_q;
      if (wr_en) begin
         if (wr_data[7]) begin
            lat_ch_d   = wr_data[6:5];
            lat_type_d = psg_reg_t'(wr_data[4]);
         end
         if (typ == ATTN) begin
            attn_d[ch] = wr_data[3:0];
         end else if (ch == 2'(NOISE_CH)) begin
            noise_d     = wr_data[2:0];
            noise_rst_d = 1'b1;
         end else begin
            for (int i = 0; i < NUM_TONE; i++) begin
               if (ch == 2'(i)) begin
                  if (wr_data[7]) freq_d[i][3:0] = wr_data[3:0];
                  else            freq_d[i][9:4] = wr_data[5:0];
                  tone_req[i] = 1'b1;
               end
            end
         end
      end
      for (int i = 0; i < NUM_TONE; i++) begin
         tone_freq_d[i] = present_period(freq_d[i]);
      end
   end

   always_comb begin
      tick_d    = '0;
      acquire_d = 1'b0;
      if (psg_en) begin
         tick_d    = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
         acquire_d = (tick_q == TICK_LAST);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         freq_q      <= '0;
         tone_freq_q <= {NUM_TONE{10'd1}};
         attn_q      <= {4{ATTN_SILENT}};
         noise_q     <= '0;
         noise_rst_q <= 1'b0;
         lat_ch_q    <= '0;
         lat_type_q  <= TONE;
         tick_q      <= '0;
         acquire_q   <= 1'b0;
      end else begin
         freq_q      <= freq_d;
         tone_freq_q <= tone_freq_d;
         attn_q      <= attn_d;
         noise_q     <= noise_d;
         noise_rst_q <= noise_rst_d;
         lat_ch_q    <= lat_ch_d;
         lat_type_q  <= lat_type_d;
         tick_q      <= tick_d;
         acquire_q   <= acquire_d;
      end
   end

   for (genvar g = 0; g < NUM_TONE; g++) begin : g_sched
      load_scheduler #(
         .DIV_CYCLES (DIV_CYCLES)
      ) u_sched (
         .clk   (clk),
         .reset (reset),
         .req   (tone_req[g]),
         .load  (tone_load[g])
      );
   end

   assign tone_freq  = tone_freq_q;
   assign attn       = attn_q;
   assign noise_ctrl = noise_q;
   assign noise_rst  = noise_rst_q;
   assign acquire    = acquire_q;

endmodule

// File: tb/tb_psg_reg_decoder.sv
// Directed bench for psg_reg_decoder: byte decode, load pacing, noise, tick, reset.
module tb_psg_reg_decoder;

   logic            clk = 1'b0;
   logic            reset;
   logic            psg_en;
   logic            wr_en;
   logic [7:0]      wr_data;
   logic [2:0][9:0] tone_freq;
   logic [2:0]      tone_load;
   logic [3:0][3:0] attn;
   logic [2:0]      noise_ctrl;
   logic            noise_rst;
   logic            acquire;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int         ld_cnt [3];
   int         ld_t   [3][32];
   logic [9:0] ld_v   [3][32];
   int         nrst_cnt = 0;
   int         acq_cnt  = 0;
   int         acq_t  [32];

   psg_reg_decoder #(
      .DIV_CYCLES (20),
      .SAMPLE_DIV (10)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .psg_en     (psg_en),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .tone_freq  (tone_freq),
      .tone_load  (tone_load),
      .attn       (attn),
      .noise_ctrl (noise_ctrl),
      .noise_rst  (noise_rst),
      .acquire    (acquire)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int c = 0; c < 3; c++) begin
         if (tone_load[c]) begin
            if (ld_cnt[c] < 32) begin
               ld_t[c][ld_cnt[c]] <= cyc;
               ld_v[c][ld_cnt[c]] <= tone_freq[c];
            end
            ld_cnt[c] <= ld_cnt[c] + 1;
         end
      end
      if (noise_rst) nrst_cnt <= nrst_cnt + 1;
      if (acquire) begin
         if (acq_cnt < 32) acq_t[acq_cnt] <= cyc;
         acq_cnt <= acq_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] b);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wr_en = 1'b0;
      end
   endtask

   function automatic int loads_total();
      return ld_cnt[0] + ld_cnt[1] + ld_cnt[2];
   endfunction

   initial begin
      int b0, b1, s0, n0, a0, e;
      reset   = 1'b0;
      psg_en  = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      check("rst_tone_freq", 32'(tone_freq), 32'({10'd1, 10'd1, 10'd1}));
      check("rst_attn",      32'(attn),      32'h0000FFFF);
      check("rst_noise",     32'(noise_ctrl), 32'd0);
      check("rst_pulses",    32'({tone_load, noise_rst, acquire}), 32'd0);
      s0 = loads_total();
      repeat (100) @(negedge clk);
      check("idle_loads",  32'(loads_total() - s0), 32'd0);
      check("idle_nrst",   32'(nrst_cnt), 32'd0);
      check("idle_acq",    32'(acq_cnt),  32'd0);

      // data byte before any latch lands on ch0 tone high bits
      b0 = ld_cnt[0];
      drive(8'h15);
      idle(40);
      check("prelatch_freq0", 32'(tone_freq[0]), 32'h150);
      check("prelatch_loads", 32'(ld_cnt[0] - b0), 32'd1);
      check("prelatch_val",   32'(ld_v[0][b0]), 32'h150);

      b0 = ld_cnt[0];
      drive(8'h8E);
      drive(8'h0F);
      idle(40);
      check("ch0_freq",    32'(tone_freq[0]), 32'h0FE);
      check("ch0_loads",   32'(ld_cnt[0] - b0), 32'd2);
      check("ch0_spacing", 32'(ld_t[0][b0+1] - ld_t[0][b0]), 32'd20);
      check("ch0_val1",    32'(ld_v[0][b0]), 32'h15E);
      check("ch0_val2",    32'(ld_v[0][b0+1]), 32'h0FE);

      b0 = ld_cnt[0];
      b1 = ld_cnt[1];
      drive(8'hA1);
      drive(8'h05);
      drive(8'h3F);
      idle(40);
      check("ch1_freq",    32'(tone_freq[1]), 32'h3F1);
      check("ch1_loads",   32'(ld_cnt[1] - b1), 32'd2);
      check("ch1_spacing", 32'(ld_t[1][b1+1] - ld_t[1][b1]), 32'd20);
      check("ch1_val1",    32'(ld_v[1][b1]), 32'h001);
      check("ch1_val2",    32'(ld_v[1][b1+1]), 32'h3F1);
      check("ch1_no_ch0",  32'(ld_cnt[0] - b0), 32'd0);

      s0 = loads_total();
      drive(8'hD3);
      idle(3);
      check("attn2_latch", 32'(attn[2]), 32'h3);
      drive(8'h07);
      idle(3);
      check("attn2_data",  32'(attn[2]), 32'h7);
      drive(8'hF2);
      idle(3);
      check("attn3_latch", 32'(attn[3]), 32'h2);
      check("attn_no_load", 32'(loads_total() - s0), 32'd0);

      n0 = nrst_cnt;
      drive(8'hE5);
      idle(3);
      check("noise_latch",  32'(noise_ctrl), 32'h5);
      check("noise_rst1",   32'(nrst_cnt - n0), 32'd1);
      drive(8'h02);
      idle(3);
      check("noise_data",   32'(noise_ctrl), 32'h2);
      check("noise_rst2",   32'(nrst_cnt - n0), 32'd2);
      check("noise_attn3",  32'(attn[3]), 32'h2);
      check("noise_no_load", 32'(loads_total() - s0), 32'd0);

      @(negedge clk);
      psg_en = 1'b1;
      e  = cyc;
      a0 = acq_cnt;
      repeat (35) @(negedge clk);
      check("acq_count",  32'(acq_cnt - a0), 32'd3);
      check("acq_first",  32'(acq_t[a0] - e), 32'd10);
      check("acq_period", 32'(acq_t[a0+2] - acq_t[a0+1]), 32'd10);
      psg_en = 1'b0;
      a0 = acq_cnt;
      repeat (25) @(negedge clk);
      check("acq_off", 32'(acq_cnt - a0), 32'd0);

      // reset with ch0 busy and pending, latched target moved to ch2 attn
      drive(8'h81);
      drive(8'h02);
      drive(8'hD5);
      idle(3);
      check("pre_rst_attn2", 32'(attn[2]), 32'h5);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_tone_freq", 32'(tone_freq), 32'({10'd1, 10'd1, 10'd1}));
      check("mid_rst_attn",      32'(attn),      32'h0000FFFF);
      check("mid_rst_noise",     32'(noise_ctrl), 32'd0);
      check("mid_rst_pulses",    32'({tone_load, noise_rst, acquire}), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      s0 = loads_total();
      repeat (40) @(negedge clk);
      check("post_rst_loads", 32'(loads_total() - s0), 32'd0);
      drive(8'h04);
      idle(3);
      check("post_rst_target", 32'(tone_freq[0]), 32'h040);
      check("post_rst_attn2",  32'(attn[2]), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
